// File: rtl/mdu_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
// The master drives operands and requests. The slave returns HI/LO and status.
interface mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done, dz
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done, dz
  );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit. It produces one product or quotient bit per cycle.
// The result lands in HI/LO 33 cycles after start.
module mdu (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t       state, state_d;
  logic [1:0]   op_q;
  logic [W-1:0] opnd;       // multiplicand (mul) or divisor (div), as a magnitude
  logic [2*W-1:0] acc;      // {partial product | remainder, multiplier | dividend/quotient}
  logic [4:0]   cnt;
  logic         neg_q;      // result or quotient needs negation
  logic         neg_r;      // remainder takes a negative dividend's sign
  logic [W-1:0] hi_q, lo_q;
  logic         busy_q, done_q, dz_q;

  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_r, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, rem;

  assign abs_a = (bus.op[0] && bus.a[W-1]) ? -bus.a : bus.a;
  assign abs_b = (bus.op[0] && bus.b[W-1]) ? -bus.b : bus.b;

  // One shift-add multiply step and one restoring divide step.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc[W-1:1]};

  assign div_r    = {acc[2*W-1:W], acc[W-1]};
  assign div_ge   = (div_r >= {1'b0, opnd});
  assign div_diff = div_r - {1'b0, opnd};
  assign div_next = {(div_ge ? div_diff[W-1:0] : div_r[W-1:0]), acc[W-2:0], div_ge};

  // Divide-by-zero keeps the raw all-ones quotient. The remainder still takes the
  // dividend's sign, so HI reads back the original dividend.
  assign prod = neg_q ? -acc : acc;
  assign quot = (neg_q && !dz_q) ? -acc[W-1:0] : acc[W-1:0];
  assign rem  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: the default assignment comes first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 2'b00;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.a;
          if (bus.mtlo) lo_q <= bus.a;
          if (bus.start) begin
            op_q   <= bus.op;
            opnd   <= bus.op[1] ? abs_b : abs_a;
            acc    <= {{W{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
            cnt    <= '0;
            neg_q  <= bus.op[0] & (bus.a[W-1] ^ bus.b[W-1]);
            neg_r  <= bus.op[0] & bus.a[W-1];
            dz_q   <= bus.op[1] & (bus.b == '0);
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          if (op_q[1]) begin
            hi_q <= rem;
            lo_q <= quot;
          end else begin
            hi_q <= prod[2*W-1:W];
            lo_q <= prod[W-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu. Stimulus pushes the expected HI/LO/dz values.
// A negedge monitor pops and compares them on every done pulse.
module tb_mdu;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          edge0;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic prev_done;
  exp_t sb[$];

  mdu_if bus();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done && prev_done) begin
        errors++;
        $display("FAIL done_width: done high for two cycles");
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
          check({e.name, "_dz"}, 64'(bus.dz), 64'(e.dz));
          check({e.name, "_latency"}, 64'(cyc - e.edge0), 64'(33));
        end
      end
    end
    prev_done = bus.done;
  end

  // Called at a negedge; leaves start high across exactly one rising edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic push, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) begin
      e.name  = name;
      e.hi    = ehi;
      e.lo    = elo;
      e.dz    = edz;
      e.edge0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_busy"}, 64'(bus.busy), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(bus.done), 64'(1));
  endtask

  initial begin
    logic [31:0] hi_prev, lo_prev;
    int edge0;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_hi",   64'(bus.hi),   64'(0));
    check("rst_lo",   64'(bus.lo),   64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dz",   64'(bus.dz),   64'(0));
    reset = 1'b0;
    @(negedge clk);

    issue("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done("multu_max");
    // Each following start is issued in the done cycle of the previous operation.
    issue("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_done("mult_neg");
    issue("mult_min", 2'b01, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 1'b0);
    wait_done("mult_min");
    issue("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done("div_neg");
    issue("divu", 2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_done("divu");
    issue("divu_zero", 2'b10, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFFFFFF, 1'b1);
    wait_done("divu_zero");
    issue("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 1'b0);
    wait_done("div_ovf");
    @(negedge clk);

    // The second start and the mthi during busy must be ignored.
    hi_prev = bus.hi;
    lo_prev = bus.lo;
    edge0 = cyc + 1;
    issue("multu_ign", 2'b00, 32'h12345678, 32'h10, 1'b1, 32'h1, 32'h23456780, 1'b0);
    while (cyc < edge0 + 4) @(negedge clk);
    bus.mthi = 1'b1;
    bus.a    = 32'hDEADBEEF;
    @(negedge clk);
    bus.mthi = 1'b0;
    while (cyc < edge0 + 9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd5;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("hold_hi", 64'(bus.hi), 64'(hi_prev));
    check("hold_lo", 64'(bus.lo), 64'(lo_prev));
    wait_done("multu_ign");
    @(negedge clk);
    check("ign_no_busy", 64'(bus.busy), 64'(0));

    // mtlo in IDLE takes effect at the next edge.
    bus.mtlo = 1'b1;
    bus.a    = 32'h1234;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'(32'h1234));
    check("mtlo_hi", 64'(bus.hi), 64'(32'h1));

    // A reset during a DIV aborts the operation, and no result is written.
    edge0 = cyc + 1;
    issue("div_abort", 2'b11, 32'hFFFFFF9C, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    while (cyc < edge0 + 19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_hi",   64'(bus.hi),   64'(0));
    check("abort_lo",   64'(bus.lo),   64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", 64'(bus.busy), 64'(0));
    issue("divu_after_rst", 2'b10, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, 1'b0);
    wait_done("divu_after_rst");
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
